wb_bus_master_mux: RTL and testbench
====================================

Name: wb_bus_master_mux

Overview:
- Datapath/control stage directly downstream of the Wishbone multi-master arbiter.
- Consumes the arbiter's one-hot grant and common-cycle signal, routes the granted master's request onto a single slave port, and returns ack/err/read data to that master only.
- Contains a bus watchdog: a slave that never answers a strobe is aborted with an error to the master, so the arbiter token can move on.

Parameters:
- N, 2, number of masters; must be ≥2 and match the arbiter.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; multiple of 8.
- TIMEOUT, 255, watchdog limit in cycles; must be ≥2.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- gnt_i  in  N  one-hot grant from the arbiter
- cyc_common_i  in  1  granted master's cyc, from the arbiter
- m_stb_i  in  N  per-master strobe
- m_we_i  in  N  per-master write enable
- m_adr_i  in  N*ADDR_W  per-master address; master k at bits [k*ADDR_W +: ADDR_W]
- m_dat_i  in  N*DATA_W  per-master write data; same packing
- m_sel_i  in  N*DATA_W/8  per-master byte select; same packing
- m_dat_o  out  DATA_W  read data, broadcast to all masters
- m_ack_o  out  N  per-master ack
- m_err_o  out  N  per-master err
- s_cyc_o  out  1  slave cyc
- s_stb_o  out  1  slave strobe
- s_we_o  out  1  slave write enable
- s_adr_o  out  ADDR_W  slave address
- s_dat_o  out  DATA_W  slave write data
- s_sel_o  out  DATA_W/8  slave byte select
- s_dat_i  in  DATA_W  slave read data
- s_ack_i  in  1  slave ack
- s_err_i  in  1  slave err
- timeout_cnt_o  out  8  saturating count of watchdog aborts

Behaviour:
- Reset (rst_n_i low, async):
  - state = IDLE, watchdog counter = 0, timeout_cnt_o = 0.
  - All outputs low.
  - Reset asserted mid-cycle drops s_cyc_o/s_stb_o immediately.
- Select:
  - Index k = position of the set bit in gnt_i; if gnt_i is not one-hot, the lowest set bit wins.
  - Routing is combinational, zero latency: s_we/adr/dat/sel_o = master k fields; m_dat_o = s_dat_i.
- States: IDLE, BUSY, ABORT.
  - IDLE:
    - s_cyc_o = cyc_common_i; s_stb_o = cyc_common_i & m_stb_i[k].
    - Enter BUSY when cyc_common_i = 1.
  - BUSY: same outputs as IDLE. Return to IDLE when cyc_common_i = 0.
  - ABORT:
    - s_cyc_o = 0, s_stb_o = 0, m_ack_o = 0, m_err_o = 0.
    - Return to IDLE in the first cycle cyc_common_i = 0.
- Response routing (outside ABORT):
  - m_ack_o[k] = s_ack_i & s_stb_o.
  - m_err_o[k] = (s_err_i & s_stb_o) | watchdog fire.
  - All other bits 0.
  - ack/err when s_stb_o = 0 are ignored.
- Watchdog counter:
  - Clears when not in BUSY, when s_stb_o = 0, or when s_ack_i or s_err_i is seen.
  - Otherwise increments each cycle.
  - Fires combinationally in the cycle the counter equals TIMEOUT-1 with s_stb_o = 1 and no ack/err.
  - That is the TIMEOUTth cycle of an unanswered strobe, counting the first strobe cycle as 1.
- On fire:
  - m_err_o[k] = 1 for that single cycle.
  - Next state = ABORT; counter cleared.
  - timeout_cnt_o increments, saturating at 255.
- Simultaneous events:
  - ack/err in the firing cycle: the slave response wins, no fire, no count.
  - s_ack_i and s_err_i together: both are forwarded; masters treat err as dominant.
- Pipelined and burst strobes: the counter clears on each ack, so each beat gets its own TIMEOUT budget.
- Grant change while BUSY is illegal (the arbiter holds the token during a cycle); no behaviour is defined.

Optional Feature:
- Macro WB_BUS_MASTER_MUX_WATCHDOG_EN.
- Defined: watchdog counter, ABORT state and timeout_cnt_o as specified above.
- Undefined:
  - No counter and no ABORT state; the FSM is IDLE/BUSY only.
  - Errors come only from s_err_i.
  - timeout_cnt_o is tied to 0. TIMEOUT is ignored.

Test Plan:
- N=2, gnt_i=01, master0 writes adr 0x10 dat 0xDEADBEEF sel 0xF, slave acks on cycle 2 -> s_adr_o=0x10, s_dat_o=0xDEADBEEF, m_ack_o=01 for one cycle, m_err_o=00.
- gnt_i=10, master1 reads, slave returns 0x12345678 with ack -> m_dat_o=0x12345678, m_ack_o=10, m_ack_o[0] never high.
- TIMEOUT=4, master0 strobes, slave silent -> m_err_o=01 on the 4th strobe cycle, then s_cyc_o=0 until cyc drops, timeout_cnt_o=1.
- TIMEOUT=4, slave acks on exactly the 4th strobe cycle -> m_ack_o=01, no err, timeout_cnt_o unchanged, state BUSY.
- 300 consecutive timeouts -> timeout_cnt_o saturates at 255.
- rst_n_i pulsed low mid-cycle with strobe pending -> all outputs 0 asynchronously, counter 0, IDLE after release; with the macro undefined, a silent slave gives no m_err_o and timeout_cnt_o stays 0.

Source files
------------

// File: rtl/wb_bus_master_mux.sv
// Wishbone bus master mux: sits behind the multi-master arbiter, routes the
// granted master's request to the single slave port and steers ack/err back to
// that master only. An optional bus watchdog aborts strobes that the slave
// never answers, so the arbiter token can move on.
//
// Optional feature macro: WB_BUS_MASTER_MUX_WATCHDOG_EN
//   defined   -> watchdog counter, ABORT state, timeout_cnt_o counts aborts
//   undefined -> IDLE/BUSY only, errors come only from s_err_i,
//                timeout_cnt_o tied to 0, TIMEOUT unused
//
// Debug: state_o exposes the FSM state (0 = IDLE, 1 = BUSY, 2 = ABORT).
//
// Handshake: the slave side is classic Wishbone. A beat completes in any
// cycle where s_stb_o is high and the slave raises s_ack_i or s_err_i; ack/err
// seen while s_stb_o is low are ignored. The strobe is held until then.
module wb_bus_master_mux #(
    parameter int N       = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [N-1:0]             gnt_i,
    input  logic                     cyc_common_i,
    input  logic [N-1:0]             m_stb_i,
    input  logic [N-1:0]             m_we_i,
    input  logic [N*ADDR_W-1:0]      m_adr_i,
    input  logic [N*DATA_W-1:0]      m_dat_i,
    input  logic [N*(DATA_W/8)-1:0]  m_sel_i,
    output logic [DATA_W-1:0]        m_dat_o,
    output logic [N-1:0]             m_ack_o,
    output logic [N-1:0]             m_err_o,
    output logic                     s_cyc_o,
    output logic                     s_stb_o,
    output logic                     s_we_o,
    output logic [ADDR_W-1:0]        s_adr_o,
    output logic [DATA_W-1:0]        s_dat_o,
    output logic [DATA_W/8-1:0]      s_sel_o,
    input  logic [DATA_W-1:0]        s_dat_i,
    input  logic                     s_ack_i,
    input  logic                     s_err_i,
    output logic [7:0]               timeout_cnt_o,
    output logic [1:0]               state_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

`ifdef WB_BUS_MASTER_MUX_WATCHDOG_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1
    } state_t;
`endif

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] sel_idx;
    logic [N-1:0]     sel_oh;
    logic             in_abort;
    logic             bus_cyc;
    logic             bus_stb;
    logic             wd_fire;

    // Master select: the lowest set grant bit wins if the grant is not one-hot.
    always_comb begin
        sel_idx = '0;
        sel_oh  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (gnt_i[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
        sel_oh[sel_idx] = 1'b1;
    end

`ifdef WB_BUS_MASTER_MUX_WATCHDOG_EN
    // Counter only has to reach TIMEOUT-1, the cycle in which it fires.
    localparam int WD_W = $clog2(TIMEOUT);

    logic [WD_W-1:0] wd_cnt_q;
    logic [7:0]      to_cnt_q;
    logic            wd_clear;

    assign in_abort = (state_q == ST_ABORT);

    // Watchdog fire: the TIMEOUTth unanswered strobe cycle in BUSY; a slave
    // response in that same cycle takes priority.
    always_comb begin
        wd_fire  = (state_q == ST_BUSY) && bus_stb && !s_ack_i && !s_err_i &&
                   (wd_cnt_q == WD_W'(TIMEOUT - 1));
        wd_clear = (state_q != ST_BUSY) || !bus_stb || s_ack_i || s_err_i || wd_fire;
    end

    // Watchdog counter: counts consecutive unanswered strobe cycles of one beat.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wd_cnt_q <= '0;
        end else if (wd_clear) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    // Abort counter: saturates at 255 so software can tell "many" from wrap.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            to_cnt_q <= '0;
        end else if (wd_fire && (to_cnt_q != 8'hFF)) begin
            to_cnt_q <= to_cnt_q + 8'd1;
        end
    end

    assign timeout_cnt_o = to_cnt_q;
`else
    assign in_abort      = 1'b0;
    assign wd_fire       = 1'b0;
    assign timeout_cnt_o = 8'd0;
`endif

    // Bus cycle/strobe as seen by the slave; ABORT holds both low.
    always_comb begin
        bus_cyc = !in_abort && cyc_common_i;
        bus_stb = bus_cyc && m_stb_i[sel_idx];
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: track the arbiter's cycle; a watchdog fire parks us in
    // ABORT until the master drops cyc.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cyc_common_i) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (wd_fire) begin
`ifdef WB_BUS_MASTER_MUX_WATCHDOG_EN
                    state_d = ST_ABORT;
`else
                    state_d = ST_BUSY;
`endif
                end else if (!cyc_common_i) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef WB_BUS_MASTER_MUX_WATCHDOG_EN
            ST_ABORT: begin
                if (!cyc_common_i) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output routing; everything is forced low while reset is held so a reset
    // in the middle of a cycle drops the slave strobe at once.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        if (rst_n_i) begin
            s_cyc_o = bus_cyc;
            s_stb_o = bus_stb;
            s_we_o  = m_we_i[sel_idx];
            s_adr_o = m_adr_i[int'(sel_idx) * ADDR_W +: ADDR_W];
            s_dat_o = m_dat_i[int'(sel_idx) * DATA_W +: DATA_W];
            s_sel_o = m_sel_i[int'(sel_idx) * SEL_W +: SEL_W];
            m_dat_o = s_dat_i;
            if (!in_abort) begin
                m_ack_o = (s_ack_i && bus_stb) ? sel_oh : '0;
                m_err_o = ((s_err_i && bus_stb) || wd_fire) ? sel_oh : '0;
            end
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_wb_bus_master_mux.sv
// Bench for wb_bus_master_mux: directed scenarios plus randomized Wishbone
// transactions, each cycle compared with a transaction-level reference model.
module tb_wb_bus_master_mux;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;
`ifdef WB_BUS_MASTER_MUX_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      gnt;
    logic              cyc;
    logic [N-1:0]      m_stb;
    logic [N-1:0]      m_we;
    logic [N*AW-1:0]   m_adr;
    logic [N*DW-1:0]   m_dat;
    logic [N*SW-1:0]   m_sel;
    logic [DW-1:0]     m_dat_o;
    logic [N-1:0]      m_ack_o;
    logic [N-1:0]      m_err_o;
    logic              s_cyc_o;
    logic              s_stb_o;
    logic              s_we_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic [DW-1:0]     s_dat;
    logic              s_ack;
    logic              s_err;
    logic [7:0]        timeout_cnt_o;
    logic [1:0]        state_o;

    wb_bus_master_mux #(.N(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .gnt_i(gnt), .cyc_common_i(cyc),
        .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr), .m_dat_i(m_dat),
        .m_sel_i(m_sel), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat), .s_ack_i(s_ack),
        .s_err_i(s_err), .timeout_cnt_o(timeout_cnt_o), .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    // Reference model: a cycle is "open" once cyc has been seen for a clock,
    // "aborted" after the watchdog kills it, "waited" counts strobe cycles the
    // slave has left unanswered in the current beat.
    bit mdl_open;
    bit mdl_aborted;
    int mdl_waited;
    int mdl_aborts;
    bit mdl_stb;
    bit mdl_fire;
    int cur_m;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_open    = 1'b0;
        mdl_aborted = 1'b0;
        mdl_waited  = 0;
        mdl_aborts  = 0;
        mdl_stb     = 1'b0;
        mdl_fire    = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_s_cyc"}, s_cyc_o, 0);
        check_eq({tag, "_s_stb"}, s_stb_o, 0);
        check_eq({tag, "_s_we"}, s_we_o, 0);
        check_eq({tag, "_s_adr"}, s_adr_o, 0);
        check_eq({tag, "_s_dat"}, s_dat_o, 0);
        check_eq({tag, "_s_sel"}, s_sel_o, 0);
        check_eq({tag, "_m_dat"}, m_dat_o, 0);
        check_eq({tag, "_m_ack"}, m_ack_o, 0);
        check_eq({tag, "_m_err"}, m_err_o, 0);
        check_eq({tag, "_to_cnt"}, timeout_cnt_o, 0);
        check_eq({tag, "_state"}, state_o, 0);
    endtask

    // Compare every output against the model (called mid-cycle, inputs stable).
    task automatic check_cycle();
        logic [N-1:0] oh;
        logic [N-1:0] e_ack;
        logic [N-1:0] e_err;
        int k;
        bit e_cyc;
        oh = gnt & (~gnt + 1'b1);
        k = 0;
        for (int i = 0; i < N; i++) if (oh[i]) k = i;
        e_cyc    = !mdl_aborted && cyc;
        mdl_stb  = e_cyc && m_stb[k];
        mdl_fire = WD && mdl_open && !mdl_aborted && mdl_stb && !s_ack && !s_err &&
                   (mdl_waited + 1 == TO);
        e_ack = (mdl_stb && s_ack) ? oh : '0;
        e_err = ((mdl_stb && s_err) || mdl_fire) ? oh : '0;
        check_eq("s_cyc", s_cyc_o, e_cyc);
        check_eq("s_stb", s_stb_o, mdl_stb);
        check_eq("s_we", s_we_o, m_we[k]);
        check_eq("s_adr", s_adr_o, m_adr[k*AW +: AW]);
        check_eq("s_dat", s_dat_o, m_dat[k*DW +: DW]);
        check_eq("s_sel", s_sel_o, m_sel[k*SW +: SW]);
        check_eq("m_dat", m_dat_o, s_dat);
        check_eq("m_ack", m_ack_o, e_ack);
        check_eq("m_err", m_err_o, e_err);
        check_eq("to_cnt", timeout_cnt_o, mdl_aborts);
        check_eq("state", state_o, mdl_aborted ? 2 : (mdl_open ? 1 : 0));
        if (e_ack != 0 && !m_we[k]) begin
            if (exp_q.size() == 0) begin
                check_eq("rd_queue_empty", exp_q.size(), 1);
            end else begin
                check_eq("rd_data", m_dat_o, exp_q.pop_front());
            end
        end
    endtask

    // Advance the model across the clock edge.
    task automatic model_update();
        if (mdl_aborted) begin
            if (!cyc) begin
                mdl_aborted = 1'b0;
                mdl_open    = 1'b0;
            end
        end else if (mdl_fire) begin
            mdl_aborted = 1'b1;
            mdl_open    = 1'b0;
            mdl_waited  = 0;
            if (mdl_aborts < 255) mdl_aborts++;
        end else begin
            mdl_waited = (mdl_open && mdl_stb && !s_ack && !s_err) ? mdl_waited + 1 : 0;
            mdl_open   = cyc;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // ---------------- driver tasks ----------------
    // Random traffic on the masters that do not own the bus.
    task automatic noise();
        for (int j = 0; j < N; j++) begin
            if (j != cur_m) begin
                m_stb[j]           = 1'($urandom);
                m_we[j]            = 1'($urandom);
                m_adr[j*AW +: AW]  = $urandom;
                m_dat[j*DW +: DW]  = $urandom;
                m_sel[j*SW +: SW]  = SW'($urandom);
            end
        end
    endtask

    task automatic txn_open(input int m, input bit extra_gnt);
        logic [N-1:0] hi;
        cur_m = m;
        hi = '0;
        for (int i = m + 1; i < N; i++) hi[i] = extra_gnt ? 1'($urandom) : 1'b0;
        gnt = hi;
        gnt[m] = 1'b1;
        cyc = 1'b1;
        m_stb[m] = 1'b0;
        noise();
        tick();
    endtask

    task automatic txn_close();
        m_stb[cur_m] = 1'b0;
        cyc = 1'b0;
        noise();
        tick();
        tick();
    endtask

    // One beat. delay = response cycle (0 = first strobe cycle), <0 = silent.
    // kind: 0 ack, 1 err, 2 ack and err together.
    task automatic beat(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                        input logic [SW-1:0] sel, input int delay, input int kind,
                        input logic [DW-1:0] rdat);
        int lim;
        bit resp;
        lim = (delay < 0) ? TO + 2 : delay;
        m_stb[cur_m]            = 1'b1;
        m_we[cur_m]             = we;
        m_adr[cur_m*AW +: AW]   = adr;
        m_dat[cur_m*DW +: DW]   = dat;
        m_sel[cur_m*SW +: SW]   = sel;
        for (int d = 0; d <= lim; d++) begin
            noise();
            resp  = (delay >= 0) && (d == delay);
            s_ack = resp && (kind != 1);
            s_err = resp && (kind != 0);
            s_dat = resp ? rdat : $urandom;
            if (s_ack && !we) exp_q.push_back(rdat);
            tick();
            if (mdl_aborted) break;
        end
        s_ack = 1'b0;
        s_err = 1'b0;
        if (!mdl_aborted) m_stb[cur_m] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        gnt = '0; cyc = 1'b0; m_stb = '0; m_we = '0;
        m_adr = '0; m_dat = '0; m_sel = '0;
        s_dat = '0; s_ack = 1'b0; s_err = 1'b0;
        cur_m = 0;
        model_reset();
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Master 0 write, slave acks on the second strobe cycle.
        txn_open(0, 1'b0);
        beat(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 0, '0);
        txn_close();

        // Master 1 read, slave returns data with ack.
        txn_open(1, 1'b0);
        beat(1'b0, 32'h44, 32'h0, 4'hF, 1, 0, 32'h12345678);
        txn_close();

        // Silent slave: aborted on the TOth strobe cycle when the watchdog exists.
        txn_open(0, 1'b0);
        beat(1'b1, 32'h20, 32'hCAFEF00D, 4'h3, -1, 0, '0);
        tick();
        tick();
        check_eq("to_cnt_after_silent", timeout_cnt_o, WD ? 1 : 0);
        txn_close();

        // Ack on exactly the TOth strobe cycle: the slave wins, cycle stays open.
        txn_open(0, 1'b0);
        beat(1'b0, 32'h30, 32'h0, 4'hF, TO - 1, 0, 32'hA5A5A5A5);
        tick();
        check_eq("state_after_late_ack", state_o, 1);
        check_eq("to_cnt_after_late_ack", timeout_cnt_o, WD ? 1 : 0);
        txn_close();

        // Randomized transactions.
        for (int t = 0; t < 150; t++) begin
            int m;
            int nb;
            m  = $urandom_range(0, N - 1);
            nb = $urandom_range(1, 3);
            txn_open(m, 1'($urandom));
            for (int b = 0; b < nb; b++) begin
                int dly;
                dly = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, TO);
                beat(1'($urandom), $urandom, $urandom, SW'($urandom), dly,
                     $urandom_range(0, 2), $urandom);
                if (mdl_aborted) break;
            end
            if (mdl_aborted) tick();
            txn_close();
        end

        // Mid-cycle async reset with a strobe pending.
        txn_open(1, 1'b0);
        m_stb[1] = 1'b1;
        m_we[1]  = 1'b0;
        m_adr[AW +: AW] = 32'h55;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        model_reset();
        cyc = 1'b0;
        m_stb = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick();
        check_eq("state_after_reset", state_o, 0);

        // Many consecutive timeouts: the abort counter saturates.
        if (WD) begin
            for (int t = 0; t < 300; t++) begin
                txn_open(0, 1'b0);
                beat(1'b1, $urandom, $urandom, 4'hF, -1, 0, '0);
                txn_close();
            end
            check_eq("to_cnt_saturated", timeout_cnt_o, 255);
        end

        check_eq("rd_queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
